imuldiv_muldiv_dispatch: RTL and testbench

Front-end stage that sits directly upstream of the iterative div unit and the iterative mul unit. It accepts one muldiv request (fn, a, b) from the processor, decodes fn, and issues the operands to exactly one unit over its val/rdy interface. It captures that unit's 64-bit result and returns it on a single muldivresp val/rdy interface. Only one operation is in flight at a time, so results return in order.

---
 rtl/imuldiv_muldiv_dispatch_pkg.sv | 35 +++
 rtl/imuldiv_muldiv_dispatch_ctrl.sv | 106 ++++++++++
 rtl/imuldiv_muldiv_dispatch.sv | 92 +++++++++
 tb/tb_imuldiv_muldiv_dispatch.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/imuldiv_muldiv_dispatch_pkg.sv
// Shared definitions for the muldiv dispatch stage: fn encoding, FSM states
// and small decode helpers used by both the control and the datapath.
package imuldiv_muldiv_dispatch_pkg;

  localparam int DATA_W = 32;
  localparam int RES_W  = 64;
  localparam int FN_W   = 3;

  localparam logic [FN_W-1:0] FN_MUL  = 3'd0;
  localparam logic [FN_W-1:0] FN_DIV  = 3'd1;
  localparam logic [FN_W-1:0] FN_DIVU = 3'd2;
  localparam logic [FN_W-1:0] FN_REM  = 3'd3;
  localparam logic [FN_W-1:0] FN_REMU = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  function automatic logic fn_is_legal(input logic [FN_W-1:0] fn);
    return (fn <= FN_REMU);
  endfunction

  function automatic logic fn_is_div(input logic [FN_W-1:0] fn);
    return (fn != FN_MUL);
  endfunction

  // Quotient and remainder come from the same divide; only signedness differs.
  function automatic logic fn_is_signed_div(input logic [FN_W-1:0] fn);
    return (fn == FN_DIV) || (fn == FN_REM);
  endfunction

endpackage

// File: rtl/imuldiv_muldiv_dispatch_ctrl.sv
// Dispatch FSM: accepts one request, steers it to the mul or div unit,
// waits for that unit's result and holds the response until consumed.
module imuldiv_muldiv_dispatch_ctrl
  import imuldiv_muldiv_dispatch_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            muldivreq_val,
  input  logic [FN_W-1:0] muldivreq_msg_fn,
  input  logic            sel_div,
  input  logic            mulreq_rdy,
  input  logic            divreq_rdy,
  input  logic            mulresp_val,
  input  logic            divresp_val,
  input  logic            muldivresp_rdy,
  output logic            muldivreq_rdy,
  output logic            mulreq_val,
  output logic            divreq_val,
  output logic            mulresp_rdy,
  output logic            divresp_rdy,
  output logic            muldivresp_val,
  output logic            req_load,
  output logic            result_load,
  output logic            result_clear
);

  state_e state;
  state_e state_next;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next     = state;
    muldivreq_rdy  = 1'b0;
    mulreq_val     = 1'b0;
    divreq_val     = 1'b0;
    mulresp_rdy    = 1'b0;
    divresp_rdy    = 1'b0;
    muldivresp_val = 1'b0;
    req_load       = 1'b0;
    result_load    = 1'b0;
    result_clear   = 1'b0;

    case (state)
      ST_IDLE: begin
        muldivreq_rdy = 1'b1;
        if (muldivreq_val) begin
          req_load = 1'b1;
          // Illegal fn never touches a unit; answer with zero immediately.
          if (fn_is_legal(muldivreq_msg_fn)) begin
            state_next = ST_ISSUE;
          end else begin
            state_next   = ST_RESP;
            result_clear = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (sel_div) begin
          divreq_val = 1'b1;
          if (divreq_rdy) state_next = ST_WAIT;
        end else begin
          mulreq_val = 1'b1;
          if (mulreq_rdy) state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (sel_div) begin
          divresp_rdy = 1'b1;
          if (divresp_val) begin
            result_load = 1'b1;
            state_next  = ST_RESP;
          end
        end else begin
          mulresp_rdy = 1'b1;
          if (mulresp_val) begin
            result_load = 1'b1;
            state_next  = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        muldivresp_val = 1'b1;
        if (muldivresp_rdy) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    // While reset is held every handshake output is forced low.
    if (reset) begin
      muldivreq_rdy  = 1'b0;
      mulreq_val     = 1'b0;
      divreq_val     = 1'b0;
      mulresp_rdy    = 1'b0;
      divresp_rdy    = 1'b0;
      muldivresp_val = 1'b0;
      req_load       = 1'b0;
      result_load    = 1'b0;
      result_clear   = 1'b0;
    end
  end

endmodule

// File: rtl/imuldiv_muldiv_dispatch.sv
// Muldiv front end: registers one request, issues it to the iterative mul or
// div unit and returns the unit's 64-bit result unchanged.
module imuldiv_muldiv_dispatch
  import imuldiv_muldiv_dispatch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [FN_W-1:0]   muldivreq_msg_fn,
  input  logic [DATA_W-1:0] muldivreq_msg_a,
  input  logic [DATA_W-1:0] muldivreq_msg_b,
  input  logic              muldivreq_val,
  output logic              muldivreq_rdy,
  output logic [RES_W-1:0]  muldivresp_msg_result,
  output logic              muldivresp_val,
  input  logic              muldivresp_rdy,
  output logic [DATA_W-1:0] mulreq_msg_a,
  output logic [DATA_W-1:0] mulreq_msg_b,
  output logic              mulreq_val,
  input  logic              mulreq_rdy,
  input  logic [RES_W-1:0]  mulresp_msg_result,
  input  logic              mulresp_val,
  output logic              mulresp_rdy,
  output logic              divreq_msg_fn,
  output logic [DATA_W-1:0] divreq_msg_a,
  output logic [DATA_W-1:0] divreq_msg_b,
  output logic              divreq_val,
  input  logic              divreq_rdy,
  input  logic [RES_W-1:0]  divresp_msg_result,
  input  logic              divresp_val,
  output logic              divresp_rdy
);

  logic [FN_W-1:0]   fn_reg;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  logic              sel_div;
  logic [RES_W-1:0]  result_reg;
  logic              req_load;
  logic              result_load;
  logic              result_clear;

  imuldiv_muldiv_dispatch_ctrl u_ctrl (
    .clk              (clk),
    .reset            (reset),
    .muldivreq_val    (muldivreq_val),
    .muldivreq_msg_fn (muldivreq_msg_fn),
    .sel_div          (sel_div),
    .mulreq_rdy       (mulreq_rdy),
    .divreq_rdy       (divreq_rdy),
    .mulresp_val      (mulresp_val),
    .divresp_val      (divresp_val),
    .muldivresp_rdy   (muldivresp_rdy),
    .muldivreq_rdy    (muldivreq_rdy),
    .mulreq_val       (mulreq_val),
    .divreq_val       (divreq_val),
    .mulresp_rdy      (mulresp_rdy),
    .divresp_rdy      (divresp_rdy),
    .muldivresp_val   (muldivresp_val),
    .req_load         (req_load),
    .result_load      (result_load),
    .result_clear     (result_clear)
  );

  // Request capture: operands are held for the whole operation.
  always_ff @(posedge clk) begin
    if (req_load) begin
      fn_reg <= muldivreq_msg_fn;
      a_reg  <= muldivreq_msg_a;
      b_reg  <= muldivreq_msg_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)         sel_div <= 1'b0;
    else if (req_load) sel_div <= fn_is_div(muldivreq_msg_fn);
  end

  // Result capture from whichever unit was engaged.
  always_ff @(posedge clk) begin
    if (reset)             result_reg <= '0;
    else if (result_clear) result_reg <= '0;
    else if (result_load)  result_reg <= sel_div ? divresp_msg_result : mulresp_msg_result;
  end

  assign mulreq_msg_a          = a_reg;
  assign mulreq_msg_b          = b_reg;
  assign divreq_msg_a          = a_reg;
  assign divreq_msg_b          = b_reg;
  assign divreq_msg_fn         = fn_is_signed_div(fn_reg);
  assign muldivresp_msg_result = result_reg;

endmodule

// File: tb/tb_imuldiv_muldiv_dispatch.sv
// Directed bench for the muldiv dispatch stage with hand-driven mul/div units.
module tb_imuldiv_muldiv_dispatch;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  muldivreq_msg_fn;
  logic [31:0] muldivreq_msg_a;
  logic [31:0] muldivreq_msg_b;
  logic        muldivreq_val;
  logic        muldivreq_rdy;
  logic [63:0] muldivresp_msg_result;
  logic        muldivresp_val;
  logic        muldivresp_rdy;
  logic [31:0] mulreq_msg_a;
  logic [31:0] mulreq_msg_b;
  logic        mulreq_val;
  logic        mulreq_rdy;
  logic [63:0] mulresp_msg_result;
  logic        mulresp_val;
  logic        mulresp_rdy;
  logic        divreq_msg_fn;
  logic [31:0] divreq_msg_a;
  logic [31:0] divreq_msg_b;
  logic        divreq_val;
  logic        divreq_rdy;
  logic [63:0] divresp_msg_result;
  logic        divresp_val;
  logic        divresp_rdy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imuldiv_muldiv_dispatch dut (
    .clk                   (clk),
    .reset                 (reset),
    .muldivreq_msg_fn      (muldivreq_msg_fn),
    .muldivreq_msg_a       (muldivreq_msg_a),
    .muldivreq_msg_b       (muldivreq_msg_b),
    .muldivreq_val         (muldivreq_val),
    .muldivreq_rdy         (muldivreq_rdy),
    .muldivresp_msg_result (muldivresp_msg_result),
    .muldivresp_val        (muldivresp_val),
    .muldivresp_rdy        (muldivresp_rdy),
    .mulreq_msg_a          (mulreq_msg_a),
    .mulreq_msg_b          (mulreq_msg_b),
    .mulreq_val            (mulreq_val),
    .mulreq_rdy            (mulreq_rdy),
    .mulresp_msg_result    (mulresp_msg_result),
    .mulresp_val           (mulresp_val),
    .mulresp_rdy           (mulresp_rdy),
    .divreq_msg_fn         (divreq_msg_fn),
    .divreq_msg_a          (divreq_msg_a),
    .divreq_msg_b          (divreq_msg_b),
    .divreq_val            (divreq_val),
    .divreq_rdy            (divreq_rdy),
    .divresp_msg_result    (divresp_msg_result),
    .divresp_val           (divresp_val),
    .divresp_rdy           (divresp_rdy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Unit-facing handshake outputs all low (nothing engaged).
  task automatic chk_units_idle(input string tag);
    chk({tag, ".mulreq_val"},  {63'd0, mulreq_val},  64'd0);
    chk({tag, ".divreq_val"},  {63'd0, divreq_val},  64'd0);
    chk({tag, ".mulresp_rdy"}, {63'd0, mulresp_rdy}, 64'd0);
    chk({tag, ".divresp_rdy"}, {63'd0, divresp_rdy}, 64'd0);
  endtask

  // Drives one legal op up to the RESP state; the mock unit returns unit_res.
  task automatic run_to_resp(input string tag, input logic [2:0] fn, input logic [31:0] a,
                             input logic [31:0] b, input logic use_div, input logic exp_dfn,
                             input logic [63:0] unit_res);
    chk({tag, ".req_rdy"}, {63'd0, muldivreq_rdy}, 64'd1);
    muldivreq_val = 1'b1; muldivreq_msg_fn = fn; muldivreq_msg_a = a; muldivreq_msg_b = b;
    step();
    // Scramble the request bus to show operands come from registers.
    muldivreq_val = 1'b0; muldivreq_msg_fn = 3'd5;
    muldivreq_msg_a = 32'hDEAD_BEEF; muldivreq_msg_b = 32'h1234_5678;
    chk({tag, ".busy_rdy"}, {63'd0, muldivreq_rdy}, 64'd0);
    chk({tag, ".mulreq_val"}, {63'd0, mulreq_val}, {63'd0, !use_div});
    chk({tag, ".divreq_val"}, {63'd0, divreq_val}, {63'd0, use_div});
    if (use_div) begin
      chk({tag, ".div_a"}, {32'd0, divreq_msg_a}, {32'd0, a});
      chk({tag, ".div_b"}, {32'd0, divreq_msg_b}, {32'd0, b});
      chk({tag, ".div_fn"}, {63'd0, divreq_msg_fn}, {63'd0, exp_dfn});
    end else begin
      chk({tag, ".mul_a"}, {32'd0, mulreq_msg_a}, {32'd0, a});
      chk({tag, ".mul_b"}, {32'd0, mulreq_msg_b}, {32'd0, b});
    end
    // Unit not ready plus a stray response: neither may be taken.
    mulresp_val = 1'b1; divresp_val = 1'b1;
    mulresp_msg_result = 64'hBAD0_BAD0_BAD0_BAD0; divresp_msg_result = 64'hBAD1_BAD1_BAD1_BAD1;
    chk({tag, ".issue_mulresp_rdy"}, {63'd0, mulresp_rdy}, 64'd0);
    chk({tag, ".issue_divresp_rdy"}, {63'd0, divresp_rdy}, 64'd0);
    step();
    mulresp_val = 1'b0; divresp_val = 1'b0;
    chk({tag, ".stall_val"}, {63'd0, (use_div ? divreq_val : mulreq_val)}, 64'd1);
    if (use_div) divreq_rdy = 1'b1; else mulreq_rdy = 1'b1;
    step();
    mulreq_rdy = 1'b0; divreq_rdy = 1'b0;
    chk({tag, ".wait_mulreq_val"}, {63'd0, mulreq_val}, 64'd0);
    chk({tag, ".wait_divreq_val"}, {63'd0, divreq_val}, 64'd0);
    chk({tag, ".wait_mulresp_rdy"}, {63'd0, mulresp_rdy}, {63'd0, !use_div});
    chk({tag, ".wait_divresp_rdy"}, {63'd0, divresp_rdy}, {63'd0, use_div});
    chk({tag, ".wait_resp_val"}, {63'd0, muldivresp_val}, 64'd0);
    if (use_div) begin
      divresp_val = 1'b1; divresp_msg_result = unit_res;
      mulresp_msg_result = 64'hBAD0_BAD0_BAD0_BAD0;
    end else begin
      mulresp_val = 1'b1; mulresp_msg_result = unit_res;
      divresp_msg_result = 64'hBAD1_BAD1_BAD1_BAD1;
    end
    step();
    mulresp_val = 1'b0; divresp_val = 1'b0;
    chk({tag, ".resp_val"}, {63'd0, muldivresp_val}, 64'd1);
    chk({tag, ".result"}, muldivresp_msg_result, unit_res);
    chk_units_idle({tag, ".resp"});
  endtask

  task automatic drain(input string tag);
    muldivresp_rdy = 1'b1;
    step();
    chk({tag, ".drained_val"}, {63'd0, muldivresp_val}, 64'd0);
    chk({tag, ".idle_rdy"}, {63'd0, muldivreq_rdy}, 64'd1);
  endtask

  initial begin
    reset = 1'b1;
    muldivreq_val = 1'b0; muldivreq_msg_fn = 3'd0; muldivreq_msg_a = '0; muldivreq_msg_b = '0;
    muldivresp_rdy = 1'b1;
    mulreq_rdy = 1'b0; mulresp_val = 1'b0; mulresp_msg_result = '0;
    divreq_rdy = 1'b0; divresp_val = 1'b0; divresp_msg_result = '0;
    step();
    step();
    chk("rst.req_rdy", {63'd0, muldivreq_rdy}, 64'd0);
    chk("rst.resp_val", {63'd0, muldivresp_val}, 64'd0);
    chk("rst.result", muldivresp_msg_result, 64'd0);
    chk_units_idle("rst");
    reset = 1'b0;
    #1;
    chk("post_rst.req_rdy", {63'd0, muldivreq_rdy}, 64'd1);

    // MUL 7 * -3 = -21
    run_to_resp("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFEB);
    drain("mul");

    // DIV -7 / 2 = -3 rem -1
    run_to_resp("div", 3'd1, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    drain("div");

    // REMU 0xFFFFFFFE / 3 = 0x55555554 rem 2
    run_to_resp("remu", 3'd4, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0, {32'h0000_0002, 32'h5555_5554});
    drain("remu");

    // REM is a signed divide
    run_to_resp("rem", 3'd3, 32'hFFFF_FFF6, 32'd3, 1'b1, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    drain("rem");

    // DIVU by zero: unit's result passes through
    run_to_resp("divz", 3'd2, 32'd9, 32'd0, 1'b1, 1'b0, {32'd9, 32'hFFFF_FFFF});
    drain("divz");

    // Illegal fn: response the cycle after accept, result cleared to zero
    muldivreq_val = 1'b1; muldivreq_msg_fn = 3'd6; muldivreq_msg_a = 32'd1; muldivreq_msg_b = 32'd1;
    step();
    muldivreq_val = 1'b0;
    chk("ill.resp_val", {63'd0, muldivresp_val}, 64'd1);
    chk("ill.result", muldivresp_msg_result, 64'd0);
    chk_units_idle("ill");
    drain("ill");
    chk_units_idle("ill.after");

    // MUL 3*5 with the consumer stalling for 5 cycles
    muldivresp_rdy = 1'b0;
    run_to_resp("stall", 3'd0, 32'd3, 32'd5, 1'b0, 1'b0, 64'h0000_0000_0000_000F);
    muldivreq_val = 1'b1; muldivreq_msg_fn = 3'd0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall.hold_val", {63'd0, muldivresp_val}, 64'd1);
      chk("stall.hold_result", muldivresp_msg_result, 64'h0000_0000_0000_000F);
      chk("stall.req_rdy", {63'd0, muldivreq_rdy}, 64'd0);
    end
    muldivreq_val = 1'b0;
    drain("stall");

    // DIV 100/7 interrupted by reset 10 cycles into the wait
    muldivreq_val = 1'b1; muldivreq_msg_fn = 3'd1; muldivreq_msg_a = 32'd100; muldivreq_msg_b = 32'd7;
    divreq_rdy = 1'b1;
    step();
    muldivreq_val = 1'b0;
    chk("rmid.divreq_val", {63'd0, divreq_val}, 64'd1);
    step();
    divreq_rdy = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("rmid.wait_divresp_rdy", {63'd0, divresp_rdy}, 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk_units_idle("rmid");
    chk("rmid.resp_val", {63'd0, muldivresp_val}, 64'd0);
    chk("rmid.result", muldivresp_msg_result, 64'd0);
    chk("rmid.req_rdy", {63'd0, muldivreq_rdy}, 64'd1);

    // DIVU 100/7 = 14 rem 2
    muldivresp_rdy = 1'b0;
    run_to_resp("divu", 3'd2, 32'd100, 32'd7, 1'b1, 1'b0, {32'h0000_0002, 32'h0000_000E});
    drain("divu");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
